// File: rtl/ddr_burst_responder.sv
// Block-RAM stand-in for a DDR controller burst interface; first read beat RD_LAT cycles after acceptance.
// DDR_RESP_STALL_EN inserts a one-cycle bubble after every 4th write request and every 4th read beat.
module ddr_burst_responder #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int MEM_DQ_WIDTH    = 16,
    parameter int MEM_AW          = 10,
    parameter int RD_LAT          = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        wr_en,
    input  logic [CTRL_ADDR_WIDTH-1:0]  wr_addr,
    input  logic [3:0]                  wr_id,
    input  logic [3:0]                  wr_len,
    output logic                        wr_ready,
    input  logic                        wr_data_en,
    input  logic [MEM_DQ_WIDTH*8-1:0]   wr_data,
    output logic                        wr_done,
    output logic                        wr_bac,
    input  logic                        rd_en,
    input  logic [CTRL_ADDR_WIDTH-1:0]  rd_addr,
    input  logic [3:0]                  rd_id,
    input  logic [3:0]                  rd_len,
    output logic [MEM_DQ_WIDTH*8-1:0]   rd_data,
    output logic                        rd_data_valid,
    output logic                        rd_last,
    output logic                        rd_done_p,
    output logic                        cmd_ovf
);

    localparam int DW = MEM_DQ_WIDTH * 8;
    localparam int WW = $clog2(RD_LAT + 1);

`ifdef DDR_RESP_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_DRAIN, WR_FIN, RD_WAIT, RD_BURST, RD_FIN
    } state_t;

    logic [DW-1:0]     mem [2**MEM_AW];
    state_t            state;
    logic              wr_full, rd_full;
    logic [MEM_AW-1:0] wr_slot_idx, rd_slot_idx, idx;
    logic [3:0]        wr_slot_len, rd_slot_len, cur_len, req_cnt, beat_cnt;
    logic [WW-1:0]     wait_cnt;
    logic              wr_window, wr_fire;

    // Beats can land while requests are still going out, so both write states accept data.
    assign wr_window = (state == WR_REQ) || (state == WR_DRAIN);
    assign wr_fire   = wr_data_en && wr_window;

    logic unused;
    assign unused = ^{wr_id, rd_id, wr_addr[2:0], rd_addr[2:0],
                      wr_addr[CTRL_ADDR_WIDTH-1:MEM_AW+3], rd_addr[CTRL_ADDR_WIDTH-1:MEM_AW+3]};

    always_ff @(posedge clk) begin
        if (rstn && wr_fire) begin
            mem[idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            wr_full       <= 1'b0;
            rd_full       <= 1'b0;
            wr_slot_idx   <= '0;
            rd_slot_idx   <= '0;
            wr_slot_len   <= '0;
            rd_slot_len   <= '0;
            idx           <= '0;
            cur_len       <= '0;
            req_cnt       <= '0;
            beat_cnt      <= '0;
            wait_cnt      <= '0;
            wr_ready      <= 1'b0;
            wr_done       <= 1'b0;
            wr_bac        <= 1'b0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            rd_last       <= 1'b0;
            rd_done_p     <= 1'b0;
            cmd_ovf       <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_full) begin
                    cmd_ovf <= 1'b1;
                end else begin
                    wr_full     <= 1'b1;
                    wr_slot_idx <= wr_addr[MEM_AW+2:3];
                    wr_slot_len <= wr_len;
                end
            end
            if (rd_en) begin
                if (rd_full) begin
                    cmd_ovf <= 1'b1;
                end else begin
                    rd_full     <= 1'b1;
                    rd_slot_idx <= rd_addr[MEM_AW+2:3];
                    rd_slot_len <= rd_len;
                end
            end
            if (wr_data_en && !wr_window) begin
                cmd_ovf <= 1'b1;
            end
            if (wr_fire) begin
                idx      <= idx + 1'b1;
                beat_cnt <= beat_cnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (wr_full) begin
                        wr_full  <= 1'b0;
                        state    <= WR_REQ;
                        wr_ready <= 1'b1;
                        wr_bac   <= 1'b1;
                        idx      <= wr_slot_idx;
                        cur_len  <= wr_slot_len;
                        req_cnt  <= '0;
                        beat_cnt <= '0;
                    end else if (rd_full) begin
                        rd_full  <= 1'b0;
                        state    <= RD_WAIT;
                        idx      <= rd_slot_idx;
                        cur_len  <= rd_slot_len;
                        beat_cnt <= '0;
                        wait_cnt <= WW'(RD_LAT - 2);
                    end
                end
                WR_REQ: begin
                    wr_bac <= 1'b0;
                    if (wr_ready) begin
                        if (req_cnt == cur_len) begin
                            wr_ready <= 1'b0;
                            state    <= WR_DRAIN;
                        end else begin
                            req_cnt <= req_cnt + 4'd1;
                            if (STALL && req_cnt[1:0] == 2'd3) begin
                                wr_ready <= 1'b0;
                            end
                        end
                    end else begin
                        wr_ready <= 1'b1;
                    end
                end
                WR_DRAIN: begin
                    if (wr_data_en && beat_cnt == cur_len) begin
                        state   <= WR_FIN;
                        wr_done <= 1'b1;
                    end
                end
                WR_FIN: begin
                    wr_done <= 1'b0;
                    state   <= IDLE;
                end
                RD_WAIT: begin
                    // The last wait cycle issues the first RAM read so data appears on schedule.
                    if (wait_cnt == '0) begin
                        rd_data       <= mem[idx];
                        rd_data_valid <= 1'b1;
                        rd_last       <= (beat_cnt == cur_len);
                        idx           <= idx + 1'b1;
                        beat_cnt      <= beat_cnt + 4'd1;
                        state         <= RD_BURST;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RD_BURST: begin
                    if (rd_data_valid && rd_last) begin
                        rd_data_valid <= 1'b0;
                        rd_last       <= 1'b0;
                        rd_done_p     <= 1'b1;
                        state         <= RD_FIN;
                    end else if (STALL && rd_data_valid && beat_cnt[1:0] == 2'd0) begin
                        rd_data_valid <= 1'b0;
                    end else begin
                        rd_data       <= mem[idx];
                        rd_data_valid <= 1'b1;
                        rd_last       <= (beat_cnt == cur_len);
                        idx           <= idx + 1'b1;
                        beat_cnt      <= beat_cnt + 4'd1;
                    end
                end
                RD_FIN: begin
                    rd_done_p <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_burst_responder.sv
// Directed bench for ddr_burst_responder with a beat-level memory model and scoreboard.
module tb_ddr_burst_responder;

    localparam int CAW    = 28;
    localparam int DQ     = 16;
    localparam int AW     = 10;
    localparam int RD_LAT = 4;
    localparam int DW     = DQ * 8;
    localparam int DEPTH  = 1 << AW;
`ifdef DDR_RESP_STALL_EN
    localparam int STALL = 1;
`else
    localparam int STALL = 0;
`endif

    logic           clk, rstn;
    logic           wr_en, wr_ready, wr_data_en, wr_done, wr_bac;
    logic [CAW-1:0] wr_addr, rd_addr;
    logic [3:0]     wr_id, wr_len, rd_id, rd_len;
    logic [DW-1:0]  wr_data, rd_data;
    logic           rd_en, rd_data_valid, rd_last, rd_done_p, cmd_ovf;

    ddr_burst_responder #(
        .CTRL_ADDR_WIDTH(CAW), .MEM_DQ_WIDTH(DQ), .MEM_AW(AW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_id(wr_id), .wr_len(wr_len),
        .wr_ready(wr_ready), .wr_data_en(wr_data_en), .wr_data(wr_data),
        .wr_done(wr_done), .wr_bac(wr_bac),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_id(rd_id), .rd_len(rd_len),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_last(rd_last),
        .rd_done_p(rd_done_p), .cmd_ovf(cmd_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_rdy = 0, n_bac = 0, n_done = 0, n_rdone = 0;
    logic [DW-1:0] last_data;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } beat_t;

    logic [DW-1:0] ref_mem [DEPTH];
    beat_t         exp_q[$];
    int            rd_span_q[$];
    int            wr_len_q[$];
    logic [DW-1:0] wq[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Beat data: tag in the upper half, position within the burst in the lower half.
    function automatic logic [DW-1:0] pat(input int tag, input int b);
        return (DW'(tag) << 64) | DW'(b);
    endfunction

    task automatic model_write(input int bidx, input int len, input int tag);
        for (int b = 0; b <= len; b++) begin
            ref_mem[(bidx + b) % DEPTH] = pat(tag, b);
            wq.push_back(pat(tag, b));
        end
        wr_len_q.push_back(len);
    endtask

    task automatic model_read(input int bidx, input int len);
        for (int b = 0; b <= len; b++) begin
            beat_t e;
            e.d    = ref_mem[(bidx + b) % DEPTH];
            e.last = (b == len);
            exp_q.push_back(e);
        end
        rd_span_q.push_back(len + 1 + STALL * (len / 4));
    endtask

    task automatic strobe(input bit we, input int widx, input int wl,
                          input bit re, input int ridx, input int rl);
        wr_en   = we;
        wr_addr = CAW'(widx * 8);
        wr_len  = 4'(wl);
        rd_en   = re;
        rd_addr = CAW'(ridx * 8);
        rd_len  = 4'(rl);
        @(posedge clk); #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wait_count(input string name, input bit rd, input int target);
        int n;
        n = 0;
        while (((rd ? n_rdone : n_done) < target) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, rd ? n_rdone : n_done, target);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Write-data source: one beat exactly one cycle after every wr_ready cycle.
    initial begin
        logic r;
        wr_data_en = 1'b0;
        wr_data    = '0;
        forever begin
            @(negedge clk);
            r = wr_ready && rstn;
            @(posedge clk); #1;
            if (r) begin
                check("wr_beat_available", wq.size() > 0, 1);
                wr_data    = (wq.size() > 0) ? wq.pop_front() : '0;
                wr_data_en = 1'b1;
            end else begin
                wr_data    = '0;
                wr_data_en = 1'b0;
            end
        end
    end

    // Scoreboard: read beats in order, burst spans, done pulses, write request spans.
    initial begin
        beat_t e;
        bit    prev_last, in_r, in_w;
        int    rstart, wstart, wcnt;
        prev_last = 0; in_r = 0; in_w = 0; rstart = 0; wstart = 0; wcnt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                prev_last = 0; in_r = 0; in_w = 0;
            end else begin
                check("rd_done_p", rd_done_p, prev_last);
                prev_last = rd_data_valid && rd_last;
                if (rd_data_valid) begin
                    if (exp_q.size() == 0) begin
                        check("rd_unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_data", rd_data, e.d);
                        check("rd_last", rd_last, e.last);
                    end
                    if (!in_r) begin
                        in_r   = 1;
                        rstart = cyc;
                    end
                    if (rd_last) begin
                        last_data = rd_data;
                        in_r      = 0;
                        if (rd_span_q.size() > 0)
                            check("rd_burst_span", cyc - rstart + 1, rd_span_q.pop_front());
                    end
                end
                if (wr_ready) begin
                    n_rdy++;
                    if (!in_w) begin
                        in_w   = 1;
                        wstart = cyc;
                        wcnt   = 0;
                        check("wr_bac_with_first_ready", wr_bac, 1);
                    end
                    wcnt++;
                    if (wr_len_q.size() > 0 && wcnt == wr_len_q[0] + 1) begin
                        check("wr_req_span", cyc - wstart + 1,
                              wr_len_q[0] + 1 + STALL * (wr_len_q[0] / 4));
                        void'(wr_len_q.pop_front());
                        in_w = 0;
                    end
                end
                if (wr_bac)    n_bac++;
                if (wr_done)   n_done++;
                if (rd_done_p) n_rdone++;
            end
        end
    end

    initial begin
        int b_rdy, b_bac, b_done, b_rdone, lat;
        rstn  = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_len = '0; wr_id = 4'hA;
        rd_en = 1'b0; rd_addr = '0; rd_len = '0; rd_id = 4'h5;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wr_ready", wr_ready, 0);
        check("reset_wr_done", wr_done, 0);
        check("reset_wr_bac", wr_bac, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_rd_valid", rd_data_valid, 0);
        check("reset_rd_last", rd_last, 0);
        check("reset_rd_done_p", rd_done_p, 0);
        check("reset_cmd_ovf", cmd_ovf, 0);
        rstn = 1'b1;
        idle(2);

        // 16-beat write of beat indices at address 0
        b_rdy = n_rdy; b_bac = n_bac; b_done = n_done;
        model_write(0, 15, 0);
        strobe(1, 0, 15, 0, 0, 0);
        wait_count("wr_done_16", 0, b_done + 1);
        check("wr_ready_cycles_16", n_rdy - b_rdy, 16);
        check("wr_bac_pulses", n_bac - b_bac, 1);
        idle(3);
        check("wr_done_single", n_done - b_done, 1);

        // 16-beat read back, latency measured from the acceptance cycle
        b_rdone = n_rdone;
        model_read(0, 15);
        strobe(0, 0, 0, 1, 0, 15);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rd_data_valid && lat < 50);
        check("rd_first_latency", lat - 1, 4);
        @(posedge clk); #1;
        wait_count("rd_done_16", 1, b_rdone + 1);
        check("rd_last_beat_data", last_data, 128'd15);
        idle(2);

        // Single-beat write/read at 0x8; neighbours untouched
        b_done = n_done; b_rdone = n_rdone;
        model_write(1, 0, 1);
        strobe(1, 1, 0, 0, 0, 0);
        wait_count("wr_done_len0", 0, b_done + 1);
        model_read(1, 0);
        strobe(0, 0, 0, 1, 1, 0);
        wait_count("rd_done_len0", 1, b_rdone + 1);
        check("rd_len0_data", last_data, 128'h1_0000_0000_0000_0000);
        model_read(0, 2);
        strobe(0, 0, 0, 1, 0, 2);
        wait_count("rd_done_neigh", 1, b_rdone + 2);
        check("rd_neighbour_0x10", last_data, 128'd2);

        // Simultaneous write and read strobes: write first, read sees new data
        b_done = n_done; b_rdone = n_rdone;
        model_write(4, 3, 2);
        model_read(4, 3);
        strobe(1, 4, 3, 1, 4, 3);
        wait_count("wr_done_simul", 0, b_done + 1);
        wait_count("rd_done_simul", 1, b_rdone + 1);
        check("rd_simul_data", last_data, 128'h2_0000_0000_0000_0003);

        // Index wrap at the top of the RAM
        b_done = n_done; b_rdone = n_rdone;
        model_write(DEPTH - 2, 3, 3);
        strobe(1, DEPTH - 2, 3, 0, 0, 0);
        wait_count("wr_done_wrap", 0, b_done + 1);
        model_read(DEPTH - 2, 3);
        strobe(0, 0, 0, 1, DEPTH - 2, 3);
        wait_count("rd_done_wrap", 1, b_rdone + 1);
        check("rd_wrap_data", last_data, 128'h3_0000_0000_0000_0003);
        model_read(2, 0);
        strobe(0, 0, 0, 1, 2, 0);
        wait_count("rd_done_wrap2", 1, b_rdone + 2);
        check("rd_after_wrap_idx2", last_data, 128'd2);
        check("cmd_ovf_clean", cmd_ovf, 0);

        // Third read while busy with the slot full is dropped
        b_rdone = n_rdone;
        model_read(0, 15);
        strobe(0, 0, 0, 1, 0, 15);
        idle(2);
        model_read(4, 0);
        strobe(0, 0, 0, 1, 4, 0);
        idle(1);
        strobe(0, 0, 0, 1, 8, 0);
        wait_count("rd_done_ovf", 1, b_rdone + 2);
        idle(40);
        check("dropped_read_never_done", n_rdone - b_rdone, 2);
        check("exp_queue_drained", exp_q.size(), 0);
        check("cmd_ovf_set", cmd_ovf, 1);
        rstn = 1'b0;
        idle(2);
        check("cmd_ovf_in_reset", cmd_ovf, 0);
        rstn = 1'b1;
        idle(2);
        check("cmd_ovf_after_reset", cmd_ovf, 0);

        // Normal traffic resumes after reset
        b_done = n_done; b_rdone = n_rdone;
        model_write(8, 1, 5);
        strobe(1, 8, 1, 0, 0, 0);
        wait_count("wr_done_post", 0, b_done + 1);
        model_read(8, 1);
        strobe(0, 0, 0, 1, 8, 1);
        wait_count("rd_done_post", 1, b_rdone + 1);
        check("rd_post_reset_data", last_data, 128'h5_0000_0000_0000_0001);

        idle(5);
        check("final_exp_queue", exp_q.size(), 0);
        check("final_wr_queue", wq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
